key_ctrl_sequencer: RTL and testbench

- Front-end control stage that feeds the seven-segment status decoder.
- Conditions raw active-low push-buttons (synchronise, debounce, press-edge detect) into single-cycle start and pause pulses.
- Counts completed slices reported by the cutting engine and raises finish after the last slice.
- Its run FSM tracks the decoder's IDLE/GO/PAUSE/DONE FSM exactly, so the two never diverge.

---
 rtl/key_ctrl_sequencer.sv | 88 ++++++++
 tb/tb_key_ctrl_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_ctrl_sequencer.sv
// key_ctrl_sequencer: conditions raw start/pause keys into pulses and sequences slice counting to finish; ports clk, rst_n, key_start_n, key_pause_n, slice_done_i -> start_o, pause_o, slice_num_o, finish_o, run_o; SIM_FAST_DEBOUNCE_EN bypasses the debounce counter
module key_ctrl_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SLICE = 16,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_pause_n,
  input  logic       slice_done_i,
  output logic       start_o,
  output logic       pause_o,
  output logic [4:0] slice_num_o,
  output logic       finish_o,
  output logic       run_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] meta_q, sync_q, acc_q, acc_d, press;
  logic start_q, start_d, pause_q, pause_d, last;
  logic [4:0] slice_q, slice_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      acc_q <= 2'b11;
    end else begin
      meta_q <= {key_pause_n, key_start_n};
      sync_q <= meta_q;
      acc_q <= acc_d;
    end
`ifdef SIM_FAST_DEBOUNCE_EN
  assign acc_d = sync_q;
`else
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  always_comb
    for (int i = 0; i < 2; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_TOP) acc_d[i] = sync_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
`endif
  // a press is the accepted level falling; bit 0 start, bit 1 pause
  assign press = acc_q & ~acc_d;
  assign last = slice_done_i && slice_q == 5'(MAX_SLICE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      pause_q <= pause_d;
      slice_q <= slice_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = press[0] ? RUN : IDLE;
      RUN: state_d = last ? DONE : press[1] ? HOLD : RUN;
      HOLD: state_d = press[1] ? RUN : HOLD;
      default: state_d = DONE;
    endcase
  end
  // the final slice outranks a simultaneous pause so finish and pause never coincide
  always_comb begin
    start_d = state_q == IDLE && press[0];
    pause_d = press[1] && (state_q == HOLD || (state_q == RUN && !last));
    slice_d = start_d ? '0 :
              (state_q == RUN && slice_done_i && slice_q != 5'(MAX_SLICE)) ? slice_q + 1'b1 : slice_q;
  end
  assign start_o = start_q;
  assign pause_o = pause_q;
  assign slice_num_o = slice_q;
  assign finish_o = state_q == DONE;
  assign run_o = state_q == RUN;
endmodule

// File: tb/tb_key_ctrl_sequencer.sv
// tb_key_ctrl_sequencer: scenario and randomized checks of key_ctrl_sequencer against a behavioural model
module tb_key_ctrl_sequencer;
  localparam int DEB = 4, MAXS = 3;
`ifdef SIM_FAST_DEBOUNCE_EN
  localparam int MDEB = 1;
`else
  localparam int MDEB = DEB;
`endif
  localparam int IDLE = 0, RUN = 1, HOLD = 2, DONE = 3;
  logic clk = 1'b0, rst_n, key_start_n, key_pause_n, slice_done_i;
  logic start_o, pause_o, finish_o, run_o;
  logic [4:0] slice_num_o;
  int checks = 0, failures = 0;
  int n_start = 0, n_pause = 0, n_both = 0;
  key_ctrl_sequencer #(.DEBOUNCE_CYCLES(DEB), .MAX_SLICE(MAXS), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_pause_n(key_pause_n),
    .slice_done_i(slice_done_i), .start_o(start_o), .pause_o(pause_o),
    .slice_num_o(slice_num_o), .finish_o(finish_o), .run_o(run_o));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (start_o) n_start++;
    if (pause_o) n_pause++;
    if (start_o && pause_o) n_both++;
  end
  // model: pad seen two edges later; a level is accepted after MDEB consecutive differing cycles
  int m_p1 [2] = '{1, 1};
  int m_p2 [2] = '{1, 1};
  int m_acc [2] = '{1, 1};
  int m_run [2] = '{0, 0};
  int m_state = IDLE, m_slice = 0;
  bit m_start = 0, m_pause = 0;
  always @(posedge clk or negedge rst_n) begin
    bit pr [2];
    int s;
    if (!rst_n) begin
      m_p1 = '{1, 1}; m_p2 = '{1, 1}; m_acc = '{1, 1}; m_run = '{0, 0};
      m_state = IDLE; m_slice = 0; m_start = 0; m_pause = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        s = m_p2[k];
        pr[k] = 0;
        if (s != m_acc[k]) begin
          m_run[k]++;
          if (m_run[k] == MDEB) begin
            m_acc[k] = s;
            m_run[k] = 0;
            pr[k] = (s == 0);
          end
        end else m_run[k] = 0;
        m_p2[k] = m_p1[k];
        m_p1[k] = (k == 1) ? int'(key_pause_n) : int'(key_start_n);
      end
      m_start = 0;
      m_pause = 0;
      case (m_state)
        IDLE: if (pr[0]) begin m_start = 1; m_state = RUN; m_slice = 0; end
        RUN: begin
          if (slice_done_i && m_slice < MAXS) m_slice++;
          if (m_slice == MAXS) m_state = DONE;
          else if (pr[1]) begin m_pause = 1; m_state = HOLD; end
        end
        HOLD: if (pr[1]) begin m_pause = 1; m_state = RUN; end
        default: ;
      endcase
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask
  task automatic hold_keys(input bit s, input bit p, input int n);
    if (s) key_start_n = 1'b0;
    if (p) key_pause_n = 1'b0;
    cycles(n);
    key_start_n = 1'b1;
    key_pause_n = 1'b1;
    cycles(10);
  endtask
  task automatic slice_pulse();
    slice_done_i = 1'b1;
    cycles(1);
    slice_done_i = 1'b0;
    cycles(1);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    checks++;
    if ({start_o, pause_o, finish_o, run_o, slice_num_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset outputs got=%b want=0", {start_o, pause_o, finish_o, run_o, slice_num_o});
    end
    rst_n = 1'b1;
    cycles(1);
  endtask
  task automatic test_start();
    int s0 = n_start;
    hold_keys(1, 0, 10);
    checks++;
    if (n_start - s0 !== 1) begin failures++; $display("FAIL start_pulses got=%0d want=1", n_start - s0); end
    checks++;
    if (run_o !== 1'b1 || slice_num_o !== 5'd0) begin
      failures++; $display("FAIL start_state run=%b slice=%0d want run=1 slice=0", run_o, slice_num_o);
    end
  endtask
  task automatic test_pause_glitch();
    int p0 = n_pause;
    hold_keys(0, 1, 2);
    checks++;
    if (n_pause - p0 !== 0 || run_o !== 1'b1) begin
      failures++; $display("FAIL glitch pauses=%0d run=%b want 0,1", n_pause - p0, run_o);
    end
    hold_keys(0, 1, 8);
    checks++;
    if (n_pause - p0 !== 1 || run_o !== 1'b0) begin
      failures++; $display("FAIL pause pauses=%0d run=%b want 1,0", n_pause - p0, run_o);
    end
    repeat (3) slice_pulse();
    checks++;
    if (slice_num_o !== 5'd0) begin failures++; $display("FAIL hold_count got=%0d want=0", slice_num_o); end
  endtask
  task automatic test_count_finish();
    int p0 = n_pause, s0 = n_start;
    hold_keys(0, 1, 8);
    checks++;
    if (n_pause - p0 !== 1 || run_o !== 1'b1) begin
      failures++; $display("FAIL resume pauses=%0d run=%b want 1,1", n_pause - p0, run_o);
    end
    for (int i = 1; i <= 3; i++) begin
      slice_pulse();
      checks++;
      if (slice_num_o !== 5'(i)) begin failures++; $display("FAIL count got=%0d want=%0d", slice_num_o, i); end
    end
    checks++;
    if (finish_o !== 1'b1 || run_o !== 1'b0) begin
      failures++; $display("FAIL finish finish=%b run=%b want 1,0", finish_o, run_o);
    end
    hold_keys(1, 0, 8);
    hold_keys(0, 1, 8);
    slice_pulse();
    checks++;
    if (n_start - s0 !== 0 || n_pause - p0 !== 1 || finish_o !== 1'b1 || slice_num_o !== 5'd3) begin
      failures++;
      $display("FAIL done_ignores starts=%0d pauses=%0d finish=%b slice=%0d", n_start - s0, n_pause - p0, finish_o, slice_num_o);
    end
  endtask
  task automatic test_final_with_pause();
    int p0;
    do_reset();
    hold_keys(1, 0, 8);
    slice_pulse();
    slice_pulse();
    p0 = n_pause;
    key_pause_n = 1'b0;
    cycles(MDEB + 1);
    slice_done_i = 1'b1;
    cycles(1);
    slice_done_i = 1'b0;
    cycles(2);
    key_pause_n = 1'b1;
    cycles(10);
    checks++;
    if (n_pause - p0 !== 0 || finish_o !== 1'b1 || slice_num_o !== 5'd3) begin
      failures++;
      $display("FAIL final_vs_pause pauses=%0d finish=%b slice=%0d want 0,1,3", n_pause - p0, finish_o, slice_num_o);
    end
    checks++;
    if (m_state !== DONE || m_pause !== 1'b0) begin
      failures++; $display("FAIL final_vs_pause_model model_state=%0d want=%0d", m_state, DONE);
    end
  endtask
  task automatic test_idle_keys();
    int s0, p0;
    do_reset();
    s0 = n_start;
    p0 = n_pause;
    hold_keys(0, 1, 8);
    checks++;
    if (n_pause - p0 !== 0 || n_start - s0 !== 0 || run_o !== 1'b0) begin
      failures++; $display("FAIL idle_pause pauses=%0d starts=%0d run=%b", n_pause - p0, n_start - s0, run_o);
    end
    hold_keys(1, 1, 8);
    checks++;
    if (n_start - s0 !== 1 || n_pause - p0 !== 0 || run_o !== 1'b1) begin
      failures++; $display("FAIL both_keys starts=%0d pauses=%0d run=%b want 1,0,1", n_start - s0, n_pause - p0, run_o);
    end
    slice_pulse();
    slice_pulse();
    checks++;
    if (slice_num_o !== 5'd2) begin failures++; $display("FAIL pre_reset_count got=%0d want=2", slice_num_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({start_o, pause_o, finish_o, run_o, slice_num_o} !== 9'd0) begin
      failures++; $display("FAIL async_reset got=%b want=0", {start_o, pause_o, finish_o, run_o, slice_num_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
  endtask
  task automatic test_random();
    logic [8:0] got, want;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 149) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 6) == 0) key_start_n = ~key_start_n;
      if ($urandom_range(0, 6) == 0) key_pause_n = ~key_pause_n;
      slice_done_i = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      got = {start_o, pause_o, finish_o, run_o, slice_num_o};
      want = {m_start, m_pause, m_state == DONE, m_state == RUN, 5'(m_slice)};
      checks++;
      if (got !== want) begin failures++; $display("FAIL random cyc=%0d got=%b want=%b", c, got, want); end
    end
    rst_n = 1'b1;
    key_start_n = 1'b1;
    key_pause_n = 1'b1;
    slice_done_i = 1'b0;
    cycles(10);
  endtask
`ifdef SIM_FAST_DEBOUNCE_EN
  task automatic test_fast();
    logic [2:0] seen;
    do_reset();
    key_start_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      key_start_n = 1'b1;
      seen[i] = start_o;
    end
    checks++;
    if (seen !== 3'b100) begin failures++; $display("FAIL fast_latency got=%b want=100", seen); end
    cycles(5);
  endtask
`endif
  task automatic test_pulse_exclusive();
    checks++;
    if (n_both !== 0) begin failures++; $display("FAIL pulse_overlap got=%0d want=0", n_both); end
  endtask
  initial begin
    rst_n = 1'b0;
    key_start_n = 1'b1;
    key_pause_n = 1'b1;
    slice_done_i = 1'b0;
    test_reset();
    test_start();
    test_pause_glitch();
    test_count_finish();
    test_final_with_pause();
    test_idle_keys();
`ifdef SIM_FAST_DEBOUNCE_EN
    test_fast();
`endif
    test_random();
    test_pulse_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
